// File: rtl/uart_baud_gen.sv
// Baud tick generator: oversample, mid-bit and end-of-bit clock-enable pulses
// from an elaboration-time rate table; rate switches only land on bit boundaries.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned NUM_RATES   = 8,
  parameter int unsigned RATE0       = 9600,
  parameter int unsigned RATE1       = 19200,
  parameter int unsigned RATE2       = 38400,
  parameter int unsigned RATE3       = 57600,
  parameter int unsigned RATE4       = 115200,
  parameter int unsigned RATE5       = 230400,
  parameter int unsigned RATE6       = 460800,
  parameter int unsigned RATE7       = 921600,
  parameter int unsigned DEFAULT_SEL = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] rate_sel,
  input  logic       rate_load,
  input  logic       resync,
  output logic [2:0] rate_cur,
  output logic       rate_ack,
  output logic       rate_err,
  output logic       pending,
  output logic       tick_os,
  output logic       tick_mid,
  output logic       tick_bit
);
  localparam int unsigned PH_W = $clog2(OVERSAMPLE);

  function automatic longint unsigned calc_div(input longint unsigned rate);
    longint unsigned den, d;
    den = rate * 64'(OVERSAMPLE);
    if (den == 64'd0) return 64'd1;
    d = (64'(CLK_HZ) + den / 64'd2) / den;
    return (d < 64'd1) ? 64'd1 : d;
  endfunction

  function automatic longint unsigned div_of(input int unsigned i);
    case (i)
      0:       return calc_div(64'(RATE0));
      1:       return calc_div(64'(RATE1));
      2:       return calc_div(64'(RATE2));
      3:       return calc_div(64'(RATE3));
      4:       return calc_div(64'(RATE4));
      5:       return calc_div(64'(RATE5));
      6:       return calc_div(64'(RATE6));
      default: return calc_div(64'(RATE7));
    endcase
  endfunction

  function automatic longint unsigned max_div();
    longint unsigned m;
    m = 64'd0;
    for (int unsigned i = 0; i < NUM_RATES; i++)
      if (div_of(i) > m) m = div_of(i);
    return m;
  endfunction

  localparam longint unsigned DIV_MAX = max_div();

  if (DIV_MAX > ((64'd1 << CNT_W) - 64'd1)) begin : g_chk_div
    $error("uart_baud_gen: divisor does not fit in CNT_W bits");
  end
  if (NUM_RATES < 1 || NUM_RATES > 8 || DEFAULT_SEL >= NUM_RATES) begin : g_chk_tab
    $error("uart_baud_gen: bad NUM_RATES / DEFAULT_SEL");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 16 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_chk_os
    $error("uart_baud_gen: OVERSAMPLE must be a power of two in 4..16");
  end

  localparam logic [7:0][CNT_W-1:0] DIV_TAB = {
    CNT_W'(div_of(7)), CNT_W'(div_of(6)), CNT_W'(div_of(5)), CNT_W'(div_of(4)),
    CNT_W'(div_of(3)), CNT_W'(div_of(2)), CNT_W'(div_of(1)), CNT_W'(div_of(0))};
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      NR      = 4'(NUM_RATES);
  localparam logic [2:0]      SEL_RST = 3'(DEFAULT_SEL);

  typedef enum logic {RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [2:0]       rate_cur_q, rate_cur_d, sel_pend_q, sel_pend_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d, div_cur;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  logic             os_q, os_d, mid_q, mid_d, bit_q, bit_d;
  logic             ack_q, ack_d, err_q, err_d, bnd_q, bnd_d;
  logic             load_ok, due, apply, clr;

  assign div_cur = DIV_TAB[rate_cur_q];

  always_comb begin
    state_d    = state_q;
    rate_cur_d = rate_cur_q;
    sel_pend_d = sel_pend_q;
    div_cnt_d  = div_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    os_d       = 1'b0;
    mid_d      = 1'b0;
    bit_d      = 1'b0;
    ack_d      = 1'b0;
    clr        = 1'b0;
    load_ok    = rate_load && ({1'b0, rate_sel} < NR);
    err_d      = rate_load && !load_ok;
    due        = enable && (div_cnt_q == div_cur - CNT_W'(1));
    // bnd_d marks a bit boundary even when resync swallows its tick_bit
    bnd_d      = due && (ph_cnt_q == PH_LAST);
    apply      = (state_q == PEND) && (bnd_q || !enable);

    if (due) begin
      div_cnt_d = '0;
      ph_cnt_d  = (ph_cnt_q == PH_LAST) ? '0 : ph_cnt_q + PH_W'(1);
      os_d      = 1'b1;
      mid_d     = (ph_cnt_q == PH_MID);
      bit_d     = bnd_d;
    end else if (enable) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (load_ok) begin
          if (!enable) begin
            rate_cur_d = rate_sel;
            ack_d      = 1'b1;
            clr        = 1'b1;
          end else begin
            state_d    = PEND;
            sel_pend_d = rate_sel;
          end
        end
      end
      PEND: begin
        if (apply) begin
          rate_cur_d = sel_pend_q;
          ack_d      = 1'b1;
          clr        = 1'b1;
          state_d    = RUN;
        end
        // a request landing on the apply cycle queues behind the applied one
        if (load_ok) begin
          sel_pend_d = rate_sel;
          state_d    = PEND;
        end
      end
      default: state_d = RUN;
    endcase

    if (clr || resync) begin
      div_cnt_d = '0;
      ph_cnt_d  = '0;
      os_d      = 1'b0;
      mid_d     = 1'b0;
      bit_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      rate_cur_q <= SEL_RST;
      sel_pend_q <= SEL_RST;
      div_cnt_q  <= '0;
      ph_cnt_q   <= '0;
      os_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      bnd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rate_cur_q <= rate_cur_d;
      sel_pend_q <= sel_pend_d;
      div_cnt_q  <= div_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      os_q       <= os_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      bnd_q      <= bnd_d;
    end
  end

  assign rate_cur = rate_cur_q;
  assign rate_ack = ack_q;
  assign rate_err = err_q;
  assign pending  = (state_q == PEND);
  assign tick_os  = os_q;
  assign tick_mid = mid_q;
  assign tick_bit = bit_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: expectations queued at stimulus time,
// popped and asserted when the DUT output is observed.
`timescale 1ns/1ps
module tb_uart_baud_gen;
  logic       clk = 1'b0;
  logic       rst, enable, rate_load, resync;
  logic [2:0] rate_sel, rate_cur;
  logic       rate_ack, rate_err, pending, tick_os, tick_mid, tick_bit;

  int cyc = 0, ack_cnt = 0, err_cnt = 0;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam int W_OS = 0, W_MID = 1, W_BIT = 2, W_ACK = 3;

  uart_baud_gen #(.NUM_RATES(5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rate_sel(rate_sel),
    .rate_load(rate_load), .resync(resync), .rate_cur(rate_cur),
    .rate_ack(rate_ack), .rate_err(rate_err), .pending(pending),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rate_ack) ack_cnt <= ack_cnt + 1;
    if (rate_err) err_cnt <= err_cnt + 1;
  end

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      W_OS:    return tick_os;
      W_MID:   return tick_mid;
      W_BIT:   return tick_bit;
      default: return rate_ack;
    endcase
  endfunction

  // at = cycle stamp of the first negedge where the signal is high, -1 on timeout
  task automatic wait_for(input int w, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(w) === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic load(input logic [2:0] s);
    rate_sel  = s;
    rate_load = 1'b1;
    @(negedge clk);
    rate_load = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, at, b, a, e0, ackc, ec, p1;
    rst = 1'b1; enable = 1'b0; rate_load = 1'b0; rate_sel = 3'd0; resync = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    push("rst_rate_cur", 0); push("rst_pending", 0); push("rst_ticks", 0); push("rst_ack_err", 0);
    check(rate_cur); check(pending); check({tick_os, tick_mid, tick_bit}); check({rate_ack, rate_err});

    // 1: immediate load while disabled, then 115200 timing (DIV=27)
    rst = 1'b0;
    @(negedge clk);
    load(3'd4);
    push("t1_ack", 1); push("t1_cur", 4);
    check(rate_ack); check(rate_cur);
    enable = 1'b1; t0 = cyc;
    push("t1_os_first", 27); push("t1_mid", 216); push("t1_bit", 432); push("t1_bit_period", 432);
    wait_for(W_OS, 100, at);  check(at - t0);
    wait_for(W_MID, 300, at); check(at - t0);
    wait_for(W_BIT, 300, at); check(at - t0); b = at;
    wait_for(W_BIT, 500, at); check(at - b);  b = at;

    // 2: mid-bit switch to 9600 (DIV=326)
    repeat (100) @(negedge clk);
    load(3'd0);
    push("t2_pending", 1); push("t2_cur_old", 4);
    check(pending); check(rate_cur);
    push("t2_old_bit", 432); push("t2_ack", 1); push("t2_cur_new", 0); push("t2_pend_clr", 0);
    push("t2_os", 326); push("t2_os_period", 326); push("t2_bit", 5216);
    wait_for(W_BIT, 500, at); check(at - b);
    @(negedge clk); check(rate_ack); check(rate_cur); check(pending); a = cyc;
    wait_for(W_OS, 400, at); check(at - a); p1 = at;
    wait_for(W_OS, 400, at); check(at - p1);
    wait_for(W_BIT, 5300, at); check(at - a); b = at;

    // 3: newest pending request wins, one ack only (57600, DIV=54)
    repeat (50) @(negedge clk); load(3'd1);
    repeat (50) @(negedge clk); load(3'd3);
    ackc = ack_cnt;
    push("t3_bit", 5216); push("t3_ack", 1); push("t3_cur", 3); push("t3_os", 54); push("t3_one_ack", 1);
    wait_for(W_BIT, 5300, at); check(at - b);
    @(negedge clk); check(rate_ack); check(rate_cur); a = cyc;
    wait_for(W_OS, 100, at); check(at - a);
    check(ack_cnt - ackc);

    // 4: out-of-range select
    ec = err_cnt;
    load(3'd6);
    push("t4_err", 1); check(rate_err);
    @(negedge clk);
    push("t4_err_once", 0); push("t4_cur", 3); push("t4_pend", 0);
    check(rate_err); check(rate_cur); check(pending);
    wait_for(W_OS, 100, p1); wait_for(W_OS, 100, at);
    push("t4_period", 54); push("t4_err_cnt", 1);
    check(at - p1); check(err_cnt - ec);

    // 5: resync at ph_cnt=10, on the cycle tick 11 was due
    wait_for(W_BIT, 1000, b);
    repeat (593) @(negedge clk);
    resync = 1'b1; @(negedge clk); resync = 1'b0; e0 = cyc;
    push("t5_no_tick", 0); push("t5_mid", 8 * 54);
    check(tick_os);
    wait_for(W_MID, 600, at); check(at - e0);

    // 5b: resync on the pending boundary still applies the rate, swallows tick_bit
    load(3'd4);
    push("t5b_pending", 1); check(pending);
    repeat (e0 + 16 * 54 - 1 - cyc) @(negedge clk);
    resync = 1'b1; @(negedge clk); resync = 1'b0;
    push("t5b_bit_suppressed", 0); check(tick_bit);
    ackc = ack_cnt;
    wait_for(W_ACK, 4, a);
    push("t5b_ack_seen", 1); push("t5b_cur", 4); push("t5b_os", 27); push("t5b_one_ack", 1);
    check(a > 0); check(rate_cur);
    wait_for(W_OS, 100, at); check(at - a);
    check(ack_cnt - ackc);

    // 5c: pending change applies as soon as enable drops
    load(3'd1);
    push("t5c_pending", 1); check(pending);
    enable = 1'b0; @(negedge clk);
    push("t5c_ack", 1); push("t5c_cur", 1); push("t5c_pend", 0);
    check(rate_ack); check(rate_cur); check(pending);
    enable = 1'b1;

    // 6: async reset while pending discards the request
    repeat (10) @(negedge clk);
    load(3'd2);
    push("t6_pending", 1); check(pending);
    ackc = ack_cnt;
    rst = 1'b1; enable = 1'b0; #1;
    push("t6_pend_clr", 0); push("t6_cur", 0); push("t6_ticks", 0); push("t6_ack_err", 0);
    check(pending); check(rate_cur); check({tick_os, tick_mid, tick_bit}); check({rate_ack, rate_err});
    repeat (4) begin @(negedge clk); enable = ~enable; end
    enable = 1'b0; @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    push("t6_no_ack", 0); push("t6_cur_after", 0);
    check(ack_cnt - ackc); check(rate_cur);
    enable = 1'b1; t0 = cyc;
    push("t6_os", 326);
    wait_for(W_OS, 400, at); check(at - t0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-tick generator for the UART TX/RX path. It replaces divided-clock outputs with single-cycle clock-enable pulses: an oversample tick, a bit tick and a mid-bit sample tick. It holds an elaboration-time table of up to 8 baud rates and switches rate glitch-free, only on a bit boundary. It also provides a phase resync input, which the RX start-bit detector uses to align sampling.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
OVERSAMPLE, 16, oversample ticks per bit; power of two in 4..16
NUM_RATES, 8, number of valid table entries (1..8)
RATE0..RATE7, 9600/19200/38400/57600/115200/230400/460800/921600, baud rate per table entry
DEFAULT_SEL, 0, table index loaded at reset
CNT_W, 16, divisor counter width; elaboration error if any divisor exceeds 2^CNT_W-1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  run tick generation; low = counters hold, no ticks
rate_sel  in  3  requested table index
rate_load  in  1  1-cycle request to switch to rate_sel
resync  in  1  1-cycle request to restart bit phase
rate_cur  out  3  currently applied table index
rate_ack  out  1  1-cycle pulse when a requested rate is applied
rate_err  out  1  1-cycle pulse when rate_sel >= NUM_RATES on rate_load
pending  out  1  a rate change is waiting for a bit boundary
tick_os  out  1  1-cycle pulse at OVERSAMPLE x baud
tick_mid  out  1  1-cycle pulse at bit centre
tick_bit  out  1  1-cycle pulse at end of each bit period

Behaviour:
- Divisor: DIV_i = (CLK_HZ + RATE_i*OVERSAMPLE/2) / (RATE_i*OVERSAMPLE), integer and rounded; clamp to a minimum of 1. Computed at elaboration only.
- Reset (async): rate_cur=DEFAULT_SEL. div_cnt=0, ph_cnt=0, pending=0. All tick, ack and err outputs are 0.
- div_cnt counts 0..DIV-1 while enable=1. tick_os=1 in the cycle where div_cnt==DIV-1, then div_cnt wraps to 0. With DIV=1, tick_os is high every enabled cycle.
- ph_cnt (log2 OVERSAMPLE bits) increments on each tick_os and wraps at OVERSAMPLE-1.
- tick_mid = tick_os & (ph_cnt==OVERSAMPLE/2-1).
- tick_bit = tick_os & (ph_cnt==OVERSAMPLE-1).
- All ticks are registered outputs, so each pulse lasts exactly 1 cycle.
- enable=0: div_cnt and ph_cnt hold their values and no ticks are generated. Raising enable resumes counting from the held values.
- State machine:
  - RUN: no change pending.
  - PEND: pending=1, new index latched in sel_pend.
- RUN + rate_load, valid sel:
  - If enable=0, apply immediately: rate_cur=sel next cycle, rate_ack pulses, counters zeroed.
  - Otherwise go to PEND.
- RUN or PEND + rate_load, invalid sel: rate_err pulses the next cycle. State, sel_pend and rate_cur are unchanged.
- PEND + rate_load, valid sel: sel_pend is overwritten (newest wins) and the state stays PEND.
- PEND, cycle where tick_bit fires:
  - That tick_bit is still issued at the old rate.
  - Next cycle: rate_cur=sel_pend, rate_ack=1, div_cnt=0, ph_cnt=0, state returns to RUN.
- PEND while enable drops to 0: apply on the next cycle as above, without waiting for a boundary.
- resync:
  - Next cycle: div_cnt=0, ph_cnt=0.
  - No tick in the cycle resync is sampled, even if a tick was due.
  - A pending rate change stays pending.
- resync in the same cycle as the pending boundary: the rate is applied (rate_ack=1) and counters are zeroed once. The tick_bit from that boundary is suppressed.
- rate_load coincident with a boundary: the boundary applies the previous sel_pend. The new request then becomes pending.
- Reset mid-operation clears everything asynchronously. A pending request is discarded and no rate_ack is issued.

Test Plan:
1. Defaults, release rst, enable=1, rate_cur=4 via immediate load with enable=0 (115200, DIV=27) -> tick_os every 27 cycles. tick_mid at cycle 216 after enable, tick_bit at cycle 432, then tick_bit period 432.
2. At 115200, rate_load sel=0 mid-bit -> pending=1. Old-rate tick_bit arrives, then rate_ack next cycle and rate_cur=0. Subsequent tick_os period is 326 and tick_bit period 5216.
3. rate_load sel=1, then sel=3 while pending -> exactly one rate_ack at the boundary, rate_cur=3, DIV=54.
4. NUM_RATES=5, rate_load sel=6 -> rate_err pulses once. rate_cur, pending and tick period unchanged.
5. resync at ph_cnt=10 -> no tick that cycle. The next tick_mid comes 8*DIV cycles later and tick_bit 16*DIV cycles later.
6. Assert rst while pending with enable toggling -> all outputs 0 immediately. rate_cur=DEFAULT_SEL, no rate_ack after release.
